cbus_arbiter: RTL and testbench
===============================

# cbus_arbiter

Arbitrates N upstream cbus masters (instruction cache, data-side load/store buffer, uncached path) onto the single cbus port that feeds the AXI bridge. A grant is held for a whole transaction, from grant until the beat carrying `last`, so bursts are never interleaved. The block also checks beat counts against the requested burst length and raises a sticky error flag on a mismatch.

## Interface
Parameters:
- NUM_MASTERS, 2: number of upstream cbus masters, 2..4.
- IDX_W, $clog2(NUM_MASTERS): width of the grant index.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- mreq  in  cbus_req_t[NUM_MASTERS]  upstream requests.
- mresp  out  cbus_resp_t[NUM_MASTERS]  upstream responses.
- oreq  out  cbus_req_t  downstream request to the AXI bridge.
- oresp  in  cbus_resp_t  downstream response (ready, last, data).
- grant_idx  out  IDX_W  index of the current or most recent grantee.
- busy  out  1  high while in the BUSY state.
- err  out  1  sticky beat-count protocol error.

## Operation
- States: IDLE and BUSY.
- **IDLE**
  - oreq is all zero.
  - Every mresp is zero.
  - If any mreq[i].valid is high, choose a winner, register it into grant_idx, load beat_cnt=0, and go to BUSY.
- **BUSY**
  - oreq = mreq[grant_idx], passed through combinationally, including valid.
  - mresp[grant_idx] = oresp.
  - Every other mresp is zero.
  - beat_cnt (5 bits) increments on each oresp.ready.
  - On oresp.ready && oresp.last, go to IDLE.
- **Masters**
  - A master must hold valid and its fields stable until it sees last.
  - If a master drops valid in BUSY, oreq.valid drops, but the grant and state are kept.
- **Error check**
  - The expected beat count is len+1, with MLEN1=0, MLEN2=1, MLEN4=3, MLEN8=7, MLEN16=15.
  - err is set if ready && last arrives with beat_cnt != oreq.len.
  - err is set if ready && !last arrives with beat_cnt == oreq.len.
  - err clears only on reset.
- **Arbitration**
  - Fixed priority: lowest index wins.
  - Round-robin policy is available; see Configuration.

## Timing
- Reset values: state=IDLE, grant_idx=0, beat_cnt=0, busy=0, err=0, oreq=0, every mresp=0. Round-robin pointer = NUM_MASTERS-1.
- Reset taken mid-burst drops the grant immediately. The downstream side must be reset in the same cycle.
- Grant latency: a valid request present at cycle T in IDLE is visible on oreq at T+1. If no other master is active, busy=1 from T+1.
- Response path: mresp of the grantee follows oresp combinationally in the same cycle.
- Release: last accepted at cycle L puts the block in IDLE at L+1. The next grant is visible on oreq at L+2, a fixed one-cycle bubble.
- Simultaneous requests at the same IDLE cycle are resolved by the active policy. Losers stay pending and see zero responses.
- No combinational path from oresp to oreq.

## Configuration
- Macro: `CBUS_ARB_ROUND_ROBIN_EN`.
- **Defined**
  - A last-grant pointer records the grantee at each BUSY→IDLE transition.
  - The search starts at pointer+1 and wraps modulo NUM_MASTERS.
  - Any continuously requesting master is served within NUM_MASTERS grants.
- **Undefined**
  - Strict fixed priority; index 0 is highest.
  - No pointer register exists.

## Structure
- Shared package (common): cbus_req_t, cbus_resp_t, the msize_t/mlen_t enums (MSIZE1/2/4, MLEN1..MLEN16), and word_t/addr_t.
- Local constants IDLE=1'b0 and BUSY=1'b1 are declared in the module.
- One sub-module, `cbus_arb_pick`: purely combinational, taking the request vector and pointer and returning winner and any_valid. The policy macro selects its logic.

## Test plan
- Single master 0: MLEN4 read at 0x1FC0_0000 with oresp.ready on every cycle and last on beat 4 → oreq valid from T+1, 4 beats delivered to mresp[0], busy falls at L+1, err=0.
- Masters 0 and 1 both request at T with fixed priority → master 0 is granted. Master 1 gets mresp=0 throughout, then oreq carries master 1's request at L+2.
- Round-robin, both masters request continuously → grants alternate 0,1,0,1 across 4 transactions.
- MLEN4 write where the slave asserts last on beat 3 → err=1 at the next cycle, still 1 after 10 more cycles.
- Master 1 drops valid for 2 cycles mid-burst → oreq.valid=0 in those cycles, grant_idx stays 1, and the burst completes normally.
- resetn low for 1 cycle during beat 2 of an MLEN8 read → state=IDLE, busy=0, err=0, all mresp=0 on the following cycle.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared cbus types and helpers used by the arbiter and its master/slave neighbours.
package cbus_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  // Encoded as beat count minus one, so the value is also the index of the final beat.
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef struct packed {
    logic       valid;
    logic       write;
    addr_t      addr;
    msize_t     size;
    mlen_t      len;
    logic [3:0] wstrb;
    word_t      wdata;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t rdata;
  } cbus_resp_t;

  localparam int BEAT_CNT_W = 5;

  function automatic logic [BEAT_CNT_W-1:0] last_beat_idx(input mlen_t len);
    return BEAT_CNT_W'(len);
  endfunction

endpackage

// File: rtl/cbus_arb_pick.sv
// Combinational winner selection; CBUS_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module cbus_arb_pick #(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_valid
);

  assign any_valid = |req;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  // Search starts just after the last grantee so it drops to lowest priority.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(ptr) + k) % NUM_MASTERS;
      if (!found && req[idx]) begin
        winner = IDX_W'(idx);
        found  = 1'b1;
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Descending scan so the lowest requesting index is the one left standing.
  always_comb begin
    winner = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) winner = IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/cbus_arbiter.sv
// Holds one cbus master's grant for a whole burst and flags beat-count mismatches.
// Optional round-robin arbitration via CBUS_ARB_ROUND_ROBIN_EN (fixed priority otherwise).
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        mreq  [NUM_MASTERS],
  output cbus_resp_t       mresp [NUM_MASTERS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_reg;
  logic [IDX_W-1:0]       grant_idx_reg;
  logic [BEAT_CNT_W-1:0]  beat_cnt_reg;
  logic                   busy_reg;
  logic                   err_reg;
  logic [IDX_W-1:0]       ptr;

  logic [NUM_MASTERS-1:0] req_vec;
  logic [IDX_W-1:0]       winner;
  logic                   any_valid;
  logic                   beat_is_final;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign req_vec[gi] = mreq[gi].valid;
      assign mresp[gi]   = (state_reg == BUSY && grant_idx_reg == IDX_W'(gi)) ? oresp : '0;
    end
  endgenerate

`ifdef CBUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr_reg <= IDX_W'(NUM_MASTERS - 1);
    end else if (state_reg == BUSY && oresp.ready && oresp.last) begin
      ptr_reg <= grant_idx_reg;
    end
  end

  assign ptr = ptr_reg;
`else
  assign ptr = '0;
`endif

  cbus_arb_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req      (req_vec),
    .ptr      (ptr),
    .winner   (winner),
    .any_valid(any_valid)
  );

  // Downstream request depends only on registered state and mreq, never on oresp.
  always_comb begin
    oreq = '0;
    if (state_reg == BUSY) oreq = mreq[grant_idx_reg];
  end

  assign beat_is_final = (beat_cnt_reg == last_beat_idx(oreq.len));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      grant_idx_reg <= '0;
      beat_cnt_reg  <= '0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            grant_idx_reg <= winner;
            beat_cnt_reg  <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= BUSY;
          end
        end
        BUSY: begin
          if (oresp.ready) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
            // Early last and overrunning beats are both protocol errors; err is sticky.
            if (oresp.last != beat_is_final) err_reg <= 1'b1;
            if (oresp.last) begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign grant_idx = grant_idx_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed, table-driven bench for cbus_arbiter plus hand sequences for reset, error and policy.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int NUM_MASTERS = 2;
  localparam int IDX_W       = $clog2(NUM_MASTERS);
  localparam logic [31:0] A0 = 32'h1FC0_0000;
  localparam logic [31:0] A1 = 32'h0000_1000;

  logic             clk;
  logic             resetn;
  cbus_req_t        mreq  [NUM_MASTERS];
  cbus_resp_t       mresp [NUM_MASTERS];
  cbus_req_t        oreq;
  cbus_resp_t       oresp;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             err;

  cbus_arbiter #(
    .NUM_MASTERS(NUM_MASTERS),
    .IDX_W      (IDX_W)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .mreq     (mreq),
    .mresp    (mresp),
    .oreq     (oreq),
    .oresp    (oresp),
    .grant_idx(grant_idx),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    mlen_t       len0;
    mlen_t       len1;
    logic        rdy;
    logic        last;
    logic        e_busy;
    logic        e_grant;
    logic        e_ov;
    logic [31:0] e_addr;
    logic        e_r0;
    logic        e_r1;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(logic rst, logic v0, logic v1, mlen_t len0, mlen_t len1,
                              logic rdy, logic last, logic e_busy, logic e_grant, logic e_ov,
                              logic [31:0] e_addr, logic e_r0, logic e_r1, logic e_err);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.v1 = v1; v.len0 = len0; v.len1 = len1;
    v.rdy = rdy; v.last = last; v.e_busy = e_busy; v.e_grant = e_grant; v.e_ov = e_ov;
    v.e_addr = e_addr; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_g;
    resetn = 1'b0;
    oresp  = '0;
    for (int m = 0; m < NUM_MASTERS; m++) mreq[m] = '0;
    mreq[0].addr = A0;
    mreq[1].addr = A1;
    mreq[0].size = MSIZE4;
    mreq[1].size = MSIZE4;

    // rst v0 v1 len0 len1 rdy last | busy grant ov addr r0 r1 err
    tbl.push_back(mk(0,0,0,MLEN4,MLEN1,0,0, 0,0,0,0 ,0,0,0)); // reset state
    tbl.push_back(mk(0,1,0,MLEN4,MLEN1,0,0, 0,0,0,0 ,0,0,0)); // request at T
    tbl.push_back(mk(0,1,0,MLEN4,MLEN1,1,0, 1,0,1,A0,1,0,0)); // beat 1 at T+1
    tbl.push_back(mk(0,1,0,MLEN4,MLEN1,1,0, 1,0,1,A0,1,0,0));
    tbl.push_back(mk(0,1,0,MLEN4,MLEN1,1,0, 1,0,1,A0,1,0,0));
    tbl.push_back(mk(0,1,0,MLEN4,MLEN1,1,1, 1,0,1,A0,1,0,0)); // beat 4 last
    tbl.push_back(mk(0,0,0,MLEN4,MLEN1,0,0, 0,0,0,0 ,0,0,0)); // idle at L+1
    tbl.push_back(mk(1,0,0,MLEN4,MLEN1,0,0, 0,0,0,0 ,0,0,0)); // reset
    tbl.push_back(mk(0,1,1,MLEN2,MLEN1,0,0, 0,0,0,0 ,0,0,0)); // both request
    tbl.push_back(mk(0,1,1,MLEN2,MLEN1,1,0, 1,0,1,A0,1,0,0)); // master 0 wins
    tbl.push_back(mk(0,1,1,MLEN2,MLEN1,1,1, 1,0,1,A0,1,0,0));
    tbl.push_back(mk(0,0,1,MLEN2,MLEN1,0,0, 0,0,0,0 ,0,0,0)); // bubble
    tbl.push_back(mk(0,0,1,MLEN2,MLEN1,0,0, 1,1,1,A1,0,0,0)); // master 1 at L+2
    tbl.push_back(mk(0,0,1,MLEN2,MLEN1,1,1, 1,1,1,A1,0,1,0));
    tbl.push_back(mk(0,0,0,MLEN2,MLEN1,0,0, 0,1,0,0 ,0,0,0)); // grant_idx retained
    tbl.push_back(mk(0,0,1,MLEN2,MLEN4,0,0, 0,1,0,0 ,0,0,0));
    tbl.push_back(mk(0,0,1,MLEN2,MLEN4,1,0, 1,1,1,A1,0,1,0));
    tbl.push_back(mk(0,0,0,MLEN2,MLEN4,0,0, 1,1,0,A1,0,0,0)); // valid dropped
    tbl.push_back(mk(0,0,0,MLEN2,MLEN4,0,0, 1,1,0,A1,0,0,0));
    tbl.push_back(mk(0,0,1,MLEN2,MLEN4,1,0, 1,1,1,A1,0,1,0));
    tbl.push_back(mk(0,0,1,MLEN2,MLEN4,1,0, 1,1,1,A1,0,1,0));
    tbl.push_back(mk(0,0,1,MLEN2,MLEN4,1,1, 1,1,1,A1,0,1,0));
    tbl.push_back(mk(0,0,0,MLEN2,MLEN4,0,0, 0,1,0,0 ,0,0,0));
    tbl.push_back(mk(0,1,0,MLEN4,MLEN4,0,0, 0,1,0,0 ,0,0,0)); // short burst
    tbl.push_back(mk(0,1,0,MLEN4,MLEN4,1,0, 1,0,1,A0,1,0,0));
    tbl.push_back(mk(0,1,0,MLEN4,MLEN4,1,0, 1,0,1,A0,1,0,0));
    tbl.push_back(mk(0,1,0,MLEN4,MLEN4,1,1, 1,0,1,A0,1,0,0)); // last on beat 3
    tbl.push_back(mk(0,0,0,MLEN4,MLEN4,0,0, 0,0,0,0 ,0,0,1)); // err set

    tick;
    tick;

    for (int i = 0; i < tbl.size(); i++) begin
      resetn       = !tbl[i].rst;
      mreq[0].valid = tbl[i].v0;
      mreq[1].valid = tbl[i].v1;
      mreq[0].len   = tbl[i].len0;
      mreq[1].len   = tbl[i].len1;
      oresp.ready   = tbl[i].rdy;
      oresp.last    = tbl[i].last;
      #1;
      $display("row %0d: busy=%b grant=%0d ovalid=%b addr=%h r0=%b r1=%b err=%b",
               i, busy, grant_idx, oreq.valid, oreq.addr, mresp[0].ready, mresp[1].ready, err);
      check($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      check($sformatf("row%0d_grant", i), 64'(grant_idx), 64'(tbl[i].e_grant));
      check($sformatf("row%0d_ovalid", i), 64'(oreq.valid), 64'(tbl[i].e_ov));
      check($sformatf("row%0d_oaddr", i), 64'(oreq.addr), 64'(tbl[i].e_addr));
      check($sformatf("row%0d_mresp0", i), 64'(mresp[0].ready), 64'(tbl[i].e_r0));
      check($sformatf("row%0d_mresp1", i), 64'(mresp[1].ready), 64'(tbl[i].e_r1));
      check($sformatf("row%0d_err", i), 64'(err), 64'(tbl[i].e_err));
      tick;
    end
    resetn = 1'b1;

    // err must stay set while idle
    for (int c = 0; c < 10; c++) begin
      check($sformatf("err_sticky_%0d", c), 64'(err), 64'd1);
      tick;
    end
    $display("sticky err held for 10 cycles");

    // reset during beat 2 of an MLEN8 read
    mreq[0].valid = 1'b1;
    mreq[0].len   = MLEN8;
    tick;
    oresp.ready = 1'b1;
    oresp.rdata = 32'hCAFE_0001;
    #1;
    check("rdata_pass", 64'(mresp[0].rdata), 64'h0000_0000_CAFE_0001);
    check("loser_zero", 64'(mresp[1]), 64'd0);
    tick;
    tick;
    resetn = 1'b0;
    tick;
    resetn        = 1'b1;
    mreq[0].valid = 1'b0;
    oresp.ready   = 1'b0;
    #1;
    $display("mid-burst reset: busy=%b err=%b", busy, err);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_mresp0", 64'(mresp[0]), 64'd0);
    check("rst_mresp1", 64'(mresp[1]), 64'd0);
    check("rst_oreq", 64'(oreq.valid), 64'd0);
    tick;

    // overrun: MLEN1 burst whose first beat is not last
    mreq[0].valid = 1'b1;
    mreq[0].len   = MLEN1;
    tick;
    oresp.ready = 1'b1;
    oresp.last  = 1'b0;
    tick;
    oresp.ready   = 1'b0;
    mreq[0].valid = 1'b0;
    #1;
    $display("overrun: err=%b", err);
    check("overrun_err", 64'(err), 64'd1);

    // both masters request continuously for 4 transactions
    resetn = 1'b0;
    tick;
    resetn        = 1'b1;
    mreq[0].valid = 1'b1;
    mreq[1].valid = 1'b1;
    mreq[0].len   = MLEN1;
    mreq[1].len   = MLEN1;
    oresp.last    = 1'b0;
    for (int t = 0; t < 4; t++) begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
      exp_g = t[0];
`else
      exp_g = 1'b0;
`endif
      tick;
      $display("policy txn %0d: grant=%0d busy=%b", t, grant_idx, busy);
      check($sformatf("policy%0d_busy", t), 64'(busy), 64'd1);
      check($sformatf("policy%0d_grant", t), 64'(grant_idx), 64'(exp_g));
      oresp.ready = 1'b1;
      oresp.last  = 1'b1;
      #1;
      check($sformatf("policy%0d_resp", t), 64'(mresp[exp_g].ready), 64'd1);
      tick;
      oresp.ready = 1'b0;
      oresp.last  = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
